// File: rtl/hash_terminal_gen.sv
// Hex text terminal: shows an input block and its digest as coloured hex digits on a VGA-timed raster.
// New data is captured by valid/ready into a shadow and copied to the display only at vertical blank.
module hash_terminal_gen #(
    parameter int unsigned IN_W      = 1024,
    parameter int unsigned OUT_W     = 256,
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned ROW_CHARS = 64,
    parameter logic [7:0]  IN_COLOR  = 8'hFC,
    parameter logic [7:0]  OUT_COLOR = 8'h1C,
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [OUT_W-1:0] out_data,
    output logic             hsync,
    output logic             vsync,
    output logic [7:0]       rgb,
    output logic             frame_start
);
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned DW       = $clog2(CLK_DIV);
    localparam int unsigned DISP_W   = IN_W + OUT_W;
    localparam int unsigned IN_DIG   = IN_W / 4;
    localparam int unsigned OUT_DIG  = OUT_W / 4;
    localparam int unsigned TOT_DIG  = IN_DIG + OUT_DIG;
    localparam int unsigned IDXW     = $clog2(TOT_DIG);
    localparam int unsigned IN_ROWS  = IN_DIG / ROW_CHARS;
    localparam int unsigned OUT_ROWS = OUT_DIG / ROW_CHARS;
    localparam int unsigned IN_BASE  = 2;
    localparam int unsigned OUT_BASE = IN_BASE + IN_ROWS + 1;
    localparam int unsigned COL0     = 8;
    localparam int unsigned HS_LO    = H_ACTIVE + H_FP;
    localparam int unsigned VS_LO    = V_ACTIVE + V_FP;

    // 8x8 hex glyphs, row 0 in the top byte, bit 7 is the leftmost pixel
    function automatic logic [7:0] font_row(input logic [3:0] nib, input logic [2:0] r);
        logic [63:0] g;
        g = '0;
        case (nib)
            4'h0: g = 64'h3C666E7666663C00;
            4'h1: g = 64'h1838181818187E00;
            4'h2: g = 64'h3C66060C30607E00;
            4'h3: g = 64'h3C66061C06663C00;
            4'h4: g = 64'h0C1C3C6C7E0C0C00;
            4'h5: g = 64'h7E607C0606663C00;
            4'h6: g = 64'h3C66607C66663C00;
            4'h7: g = 64'h7E660C1818181800;
            4'h8: g = 64'h3C66663C66663C00;
            4'h9: g = 64'h3C66663E06663C00;
            4'hA: g = 64'h183C667E66666600;
            4'hB: g = 64'h7C66667C66667C00;
            4'hC: g = 64'h3C66606060663C00;
            4'hD: g = 64'h786C6666666C7800;
            4'hE: g = 64'h7E60607860607E00;
            4'hF: g = 64'h7E60607860606000;
            default: g = '0;
        endcase
        return 8'(g >> {~r, 3'b000});
    endfunction

    logic [DW-1:0]     div_q, div_d;
    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic [DISP_W-1:0] shadow_q, shadow_d, disp_q, disp_d;
    logic              pending_q, pending_d, ready_q, ready_d, fs_q, fs_d;
    logic              s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d, s1_on_q, s1_on_d, s1_out_q, s1_out_d;
    logic [IDXW-1:0]   s1_idx_q, s1_idx_d;
    logic [2:0]        s1_gx_q, s1_gx_d, s1_gy_q, s1_gy_d;
    logic              hs_q, hs_d, vs_q, vs_d;
    logic [7:0]        rgb_q, rgb_d;

    logic        pe_c, apply_c, act_c, colok_c, in_row_c, out_row_c, lit_c;
    logic [31:0] col_c, row_c, dig_c, shift_c;
    logic [3:0]  nib_c;
    logic [7:0]  glyph_c;

    assign pe_c    = (div_q == DW'(CLK_DIV - 1));
    assign apply_c = pe_c && (32'(h_q) == H_TOTAL - 1) && (32'(v_q) == V_ACTIVE - 1);

    // Stage-1 address math: which digit cell (if any) the counters point at
    assign col_c     = 32'(h_q) >> 3;
    assign row_c     = 32'(v_q) >> 3;
    assign act_c     = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
    assign colok_c   = (col_c >= COL0) && (col_c < COL0 + ROW_CHARS);
    assign in_row_c  = (row_c >= IN_BASE) && (row_c < IN_BASE + IN_ROWS);
    assign out_row_c = (row_c >= OUT_BASE) && (row_c < OUT_BASE + OUT_ROWS);
    assign dig_c     = in_row_c ? (row_c - IN_BASE) * ROW_CHARS + col_c - COL0
                                : IN_DIG + (row_c - OUT_BASE) * ROW_CHARS + col_c - COL0;

    // Stage-2 glyph lookup; digit 0 is the most significant nibble of {in, out}
    assign shift_c = 4 * (TOT_DIG - 1 - 32'(s1_idx_q));
    assign nib_c   = 4'(disp_q >> shift_c);
    assign glyph_c = font_row(nib_c, s1_gy_q);
    assign lit_c   = s1_on_q && glyph_c[~s1_gx_q];

    always_comb begin
        div_d     = pe_c ? '0 : div_q + DW'(1);
        h_d       = h_q;
        v_d       = v_q;
        shadow_d  = shadow_q;
        disp_d    = disp_q;
        pending_d = pending_q;
        ready_d   = ready_q;
        fs_d      = apply_c;
        s1_hs_d   = s1_hs_q;
        s1_vs_d   = s1_vs_q;
        s1_on_d   = s1_on_q;
        s1_out_d  = s1_out_q;
        s1_idx_d  = s1_idx_q;
        s1_gx_d   = s1_gx_q;
        s1_gy_d   = s1_gy_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        rgb_d     = rgb_q;

        if (pe_c) begin
            if (32'(h_q) == H_TOTAL - 1) begin
                h_d = '0;
                v_d = (32'(v_q) == V_TOTAL - 1) ? '0 : v_q + VW'(1);
            end else begin
                h_d = h_q + HW'(1);
            end
            s1_hs_d  = !((32'(h_q) >= HS_LO) && (32'(h_q) < HS_LO + H_SYNC));
            s1_vs_d  = !((32'(v_q) >= VS_LO) && (32'(v_q) < VS_LO + V_SYNC));
            s1_on_d  = act_c && colok_c && (in_row_c || out_row_c);
            s1_out_d = !in_row_c;
            s1_idx_d = IDXW'(dig_c);
            s1_gx_d  = h_q[2:0];
            s1_gy_d  = v_q[2:0];
            hs_d     = s1_hs_q;
            vs_d     = s1_vs_q;
            rgb_d    = lit_c ? (s1_out_q ? OUT_COLOR : IN_COLOR) : 8'h00;
        end

        // Apply consumes the old shadow; a capture can only start once not pending
        if (apply_c && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
            ready_d   = 1'b1;
        end
        if (load_valid && ready_q) begin
            shadow_d  = {in_data, out_data};
            pending_d = 1'b1;
            ready_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q     <= '0;
            h_q       <= '0;
            v_q       <= '0;
            shadow_q  <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            ready_q   <= 1'b1;
            fs_q      <= 1'b0;
            s1_hs_q   <= 1'b1;
            s1_vs_q   <= 1'b1;
            s1_on_q   <= 1'b0;
            s1_out_q  <= 1'b0;
            s1_idx_q  <= '0;
            s1_gx_q   <= '0;
            s1_gy_q   <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            rgb_q     <= 8'h00;
        end else begin
            div_q     <= div_d;
            h_q       <= h_d;
            v_q       <= v_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
            fs_q      <= fs_d;
            s1_hs_q   <= s1_hs_d;
            s1_vs_q   <= s1_vs_d;
            s1_on_q   <= s1_on_d;
            s1_out_q  <= s1_out_d;
            s1_idx_q  <= s1_idx_d;
            s1_gx_q   <= s1_gx_d;
            s1_gy_q   <= s1_gy_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            rgb_q     <= rgb_d;
        end
    end

    assign load_ready  = ready_q;
    assign frame_start = fs_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign rgb         = rgb_q;
endmodule

// File: tb/tb_hash_terminal_gen.sv
// Bench for hash_terminal_gen on a shrunken raster: every clock the outputs are compared with a
// model that derives the pixel position from elapsed pixel ticks and renders digits from the font table.
module tb_hash_terminal_gen;
    localparam int unsigned IN_W      = 32;
    localparam int unsigned OUT_W     = 16;
    localparam int unsigned CLK_DIV   = 2;
    localparam int unsigned ROW_CHARS = 4;
    localparam logic [7:0]  IN_COLOR  = 8'hFC;
    localparam logic [7:0]  OUT_COLOR = 8'h1C;
    localparam int unsigned H_ACTIVE = 96, H_FP = 4, H_SYNC = 8, H_BP = 4;
    localparam int unsigned V_ACTIVE = 48, V_FP = 1, V_SYNC = 2, V_BP = 3;
    localparam int unsigned HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned FRAME    = HT * VT;
    localparam int unsigned IN_DIG   = IN_W / 4;
    localparam int unsigned OUT_DIG  = OUT_W / 4;
    localparam int unsigned IN_ROWS  = IN_DIG / ROW_CHARS;
    localparam int unsigned OUT_ROWS = OUT_DIG / ROW_CHARS;
    localparam int unsigned OUT_BASE = 2 + IN_ROWS + 1;

    localparam logic [63:0] FONT [16] = '{
        64'h3C666E7666663C00, 64'h1838181818187E00, 64'h3C66060C30607E00, 64'h3C66061C06663C00,
        64'h0C1C3C6C7E0C0C00, 64'h7E607C0606663C00, 64'h3C66607C66663C00, 64'h7E660C1818181800,
        64'h3C66663C66663C00, 64'h3C66663E06663C00, 64'h183C667E66666600, 64'h7C66667C66667C00,
        64'h3C66606060663C00, 64'h786C6666666C7800, 64'h7E60607860607E00, 64'h7E60607860606000
    };

    logic             clk = 1'b0;
    logic             rst_n, load_valid, load_ready, hsync, vsync, frame_start;
    logic [IN_W-1:0]  in_data;
    logic [OUT_W-1:0] out_data;
    logic [7:0]       rgb;

    always #5 clk = ~clk;

    hash_terminal_gen #(
        .IN_W(IN_W), .OUT_W(OUT_W), .CLK_DIV(CLK_DIV), .ROW_CHARS(ROW_CHARS),
        .IN_COLOR(IN_COLOR), .OUT_COLOR(OUT_COLOR),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
        .in_data(in_data), .out_data(out_data), .hsync(hsync), .vsync(vsync),
        .rgb(rgb), .frame_start(frame_start)
    );

    int unsigned total, bad;
    int unsigned cyc, n;
    logic             m_pend, m_ready, m_fs;
    logic [IN_W-1:0]  m_sh_in, m_in, pat_in;
    logic [OUT_W-1:0] m_sh_out, m_out, pat_out;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected colour of raster pixel (h,v) for the model's current display contents
    function automatic logic [7:0] exp_rgb(input int unsigned h, input int unsigned v);
        int unsigned col, row, k;
        logic [3:0]  nib;
        logic [7:0]  color;
        logic [63:0] g;
        if (h >= H_ACTIVE || v >= V_ACTIVE) return 8'h00;
        col = h / 8;
        row = v / 8;
        if (col < 8 || col >= 8 + ROW_CHARS) return 8'h00;
        if (row >= 2 && row < 2 + IN_ROWS) begin
            k     = (row - 2) * ROW_CHARS + col - 8;
            nib   = 4'(m_in >> (4 * (IN_DIG - 1 - k)));
            color = IN_COLOR;
        end else if (row >= OUT_BASE && row < OUT_BASE + OUT_ROWS) begin
            k     = (row - OUT_BASE) * ROW_CHARS + col - 8;
            nib   = 4'(m_out >> (4 * (OUT_DIG - 1 - k)));
            color = OUT_COLOR;
        end else begin
            return 8'h00;
        end
        g = FONT[nib];
        g = g >> (63 - 8 * (v % 8) - (h % 8));
        return g[0] ? color : 8'h00;
    endfunction

    // One clock: advance the model with the inputs seen at this edge, then compare
    task automatic step();
        logic        cap, ehs, evs;
        logic [7:0]  er;
        int unsigned p, h, v;
        @(posedge clk);
        if (!rst_n) begin
            cyc = 0; n = 0; m_pend = 1'b0; m_ready = 1'b1; m_fs = 1'b0;
            m_sh_in = '0; m_sh_out = '0; m_in = '0; m_out = '0;
        end else begin
            cyc++;
            cap  = load_valid && m_ready;
            m_fs = 1'b0;
            if (cyc % CLK_DIV == 0) begin
                n++;
                if (n % FRAME == V_ACTIVE * HT) begin
                    m_fs = 1'b1;
                    if (m_pend) begin
                        m_in = m_sh_in; m_out = m_sh_out; m_pend = 1'b0; m_ready = 1'b1;
                    end
                end
            end
            if (cap) begin
                m_sh_in = in_data; m_sh_out = out_data; m_pend = 1'b1; m_ready = 1'b0;
            end
        end
        #1;
        if (n < 2) begin
            ehs = 1'b1; evs = 1'b1; er = 8'h00;
        end else begin
            p   = (n - 2) % FRAME;
            h   = p % HT;
            v   = p / HT;
            ehs = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
            evs = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
            er  = exp_rgb(h, v);
        end
        check_eq("pixel{hs,vs,rgb}", 64'({hsync, vsync, rgb}), 64'({ehs, evs, er}));
        check_eq("hshake{ready,fs}", 64'({load_ready, frame_start}), 64'({m_ready, m_fs}));
    endtask

    task automatic run(input int unsigned k);
        repeat (k) step();
    endtask

    task automatic run_until_fs();
        for (int i = 0; i < int'(FRAME * CLK_DIV) + 16; i++) begin
            step();
            if (frame_start) break;
        end
        check_eq("frame_start_seen", 64'(frame_start), 64'd1);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; n = 0;
        m_pend = 1'b0; m_ready = 1'b1; m_fs = 1'b0;
        m_sh_in = '0; m_sh_out = '0; m_in = '0; m_out = '0;
        rst_n = 1'b0; load_valid = 1'b0; in_data = '0; out_data = '0;
        run(3);
        check_eq("reset_rgb", 64'(rgb), 64'h00);
        check_eq("reset_ready", 64'(load_ready), 64'd1);
        rst_n = 1'b1;

        // Idle frame renders all-zero digits
        run_until_fs();

        // Fixed pattern 0123.. / FFFF; extra valids while pending must be ignored
        pat_in = '0;
        for (int i = 0; i < int'(IN_DIG); i++) pat_in = (pat_in << 4) | IN_W'(i % 16);
        pat_out = '1;
        in_data = pat_in; out_data = pat_out; load_valid = 1'b1;
        step();
        check_eq("ready_drop", 64'(load_ready), 64'd0);
        in_data = IN_W'($urandom); out_data = OUT_W'($urandom);
        run(20);
        load_valid = 1'b0;
        run_until_fs();

        // Retry after apply is captured immediately
        in_data = IN_W'($urandom); out_data = OUT_W'($urandom); load_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (!load_ready) break;
        end
        check_eq("retry_captured", 64'(load_ready), 64'd0);
        load_valid = 1'b0;
        run_until_fs();
        run(V_ACTIVE * HT * CLK_DIV - 400);

        // Pending capture then reset in the middle of the active area
        in_data = IN_W'($urandom); out_data = OUT_W'($urandom); load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        run(5);
        rst_n = 1'b0;
        run(3);
        check_eq("midreset_ready", 64'(load_ready), 64'd1);
        check_eq("midreset_sync", 64'({hsync, vsync}), 64'd3);
        rst_n = 1'b1;
        run_until_fs();
        run(V_ACTIVE * HT * CLK_DIV);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
